soc_system_valve_ctrl_timed: RTL and testbench

//  Avalon-MM slave driving NUM_CH valve outputs. Adds atomic SET/CLR access and a
//  per-channel auto-off timer (safety timeout) to plain output-register control.

---
 rtl/soc_system_valve_pkg.sv | 22 ++
 rtl/valve_chan_timer.sv | 40 ++++
 rtl/soc_system_valve_ctrl_timed.sv | 168 ++++++++++++++++
 tb/tb_soc_system_valve_ctrl_timed.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_valve_pkg.sv
// +----------------------------------------------------------------------------+
// | soc_system_valve_pkg: register offsets and limits for the valve controller |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package soc_system_valve_pkg;

  localparam logic [2:0] VC_DATA     = 3'd0;
  localparam logic [2:0] VC_SET      = 3'd1;
  localparam logic [2:0] VC_CLR      = 3'd2;
  localparam logic [2:0] VC_CH_SEL   = 3'd3;
  localparam logic [2:0] VC_TIMEOUT  = 3'd4;
  localparam logic [2:0] VC_EXPIRED  = 3'd5;
  localparam logic [2:0] VC_IRQ_MASK = 3'd6;

  localparam int VC_MAX_CH   = 16;
  localparam int VC_CH_SEL_W = $clog2(VC_MAX_CH);

endpackage

`default_nettype wire

// File: rtl/valve_chan_timer.sv
// +----------------------------------------------------------------------------+
// | valve_chan_timer: per-channel auto-off countdown in prescaler ticks        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module valve_chan_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             arm,
  input  logic             disarm,
  input  logic [TMR_W-1:0] timeout,
  output logic             expire,
  output logic [TMR_W-1:0] cnt
);

  logic [TMR_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (arm) begin
      r_cnt <= timeout;
    end else if (disarm) begin
      r_cnt <= '0;
    end else if (tick && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A re-arm in the same cycle suppresses the expiry; a disarm does not.
  assign expire = tick && !arm && (r_cnt == TMR_W'(1));
  assign cnt    = r_cnt;

endmodule

`default_nettype wire

// File: rtl/soc_system_valve_ctrl_timed.sv
// +----------------------------------------------------------------------------+
// | soc_system_valve_ctrl_timed: Avalon-MM valve PIO with SET/CLR and auto-off |
// | Optional: VALVE_CTRL_IRQ_EN enables IRQ_MASK and the irq output            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module soc_system_valve_ctrl_timed
  import soc_system_valve_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int TMR_W     = 16,
  parameter int PRESC_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] out_port,
  output logic              irq
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  logic                           w_wr;
  logic                           w_tick;
  logic [PW-1:0]                  r_presc;
  logic [NUM_CH-1:0]              r_out, r_exp;
  logic [VC_CH_SEL_W-1:0]         r_ch_sel;
  logic [NUM_CH-1:0][TMR_W-1:0]   r_timeout;
  logic [NUM_CH-1:0][TMR_W-1:0]   w_cnt;
  logic [TMR_W-1:0]               w_sel_timeout;
  logic [NUM_CH-1:0]              w_out_wr, w_set, w_off, w_w1c;
  logic [NUM_CH-1:0]              w_arm, w_disarm, w_expire;

  assign w_wr   = chipselect && !write_n;
  assign w_tick = (r_presc == PW'(PRESC_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_out_wr = r_out;
    w_set    = '0;
    w_off    = '0;
    w_w1c    = '0;
    if (w_wr) begin
      case (address)
        VC_DATA: begin
          w_out_wr = writedata[NUM_CH-1:0];
          w_set    = writedata[NUM_CH-1:0];
          w_off    = ~writedata[NUM_CH-1:0];
        end
        VC_SET: begin
          w_out_wr = r_out | writedata[NUM_CH-1:0];
          w_set    = writedata[NUM_CH-1:0];
        end
        VC_CLR: begin
          w_out_wr = r_out & ~writedata[NUM_CH-1:0];
          w_off    = writedata[NUM_CH-1:0];
        end
        VC_EXPIRED: w_w1c = writedata[NUM_CH-1:0];
        default: ;
      endcase
    end
    // Counters already at zero need no disarm.
    for (int i = 0; i < NUM_CH; i++) begin
      w_arm[i]    = w_set[i] && (r_timeout[i] != '0);
      w_disarm[i] = w_off[i] && (w_cnt[i] != '0);
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      valve_chan_timer #(.TMR_W(TMR_W)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick && r_out[g]),
        .arm     (w_arm[g]),
        .disarm  (w_disarm[g]),
        .timeout (r_timeout[g]),
        .expire  (w_expire[g]),
        .cnt     (w_cnt[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out     <= '0;
      r_exp     <= '0;
      r_ch_sel  <= '0;
      r_timeout <= '0;
    end else begin
      r_out <= w_out_wr & ~w_expire;
      r_exp <= (r_exp & ~w_w1c) | w_expire;
      if (w_wr && (address == VC_CH_SEL) && (writedata < 32'(NUM_CH))) begin
        r_ch_sel <= writedata[VC_CH_SEL_W-1:0];
      end
      if (w_wr && (address == VC_TIMEOUT)) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_ch_sel == VC_CH_SEL_W'(i)) begin
            r_timeout[i] <= writedata[TMR_W-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    w_sel_timeout = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_ch_sel == VC_CH_SEL_W'(i)) begin
        w_sel_timeout = r_timeout[i];
      end
    end
  end

`ifdef VALVE_CTRL_IRQ_EN
  logic [NUM_CH-1:0] r_irq_mask;
  logic              r_irq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (address == VC_IRQ_MASK)) begin
        r_irq_mask <= writedata[NUM_CH-1:0];
      end
      r_irq <= |(r_exp & r_irq_mask);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      VC_DATA:     readdata[NUM_CH-1:0]      = r_out;
      VC_CH_SEL:   readdata[VC_CH_SEL_W-1:0] = r_ch_sel;
      VC_TIMEOUT:  readdata[TMR_W-1:0]       = w_sel_timeout;
      VC_EXPIRED:  readdata[NUM_CH-1:0]      = r_exp;
`ifdef VALVE_CTRL_IRQ_EN
      VC_IRQ_MASK: readdata[NUM_CH-1:0]      = r_irq_mask;
`endif
      default: ;
    endcase
  end

  assign out_port = r_out;

endmodule

`default_nettype wire

// File: tb/tb_soc_system_valve_ctrl_timed.sv
// +----------------------------------------------------------------------------+
// | tb_soc_system_valve_ctrl_timed: directed + random bench with tick model    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_soc_system_valve_ctrl_timed;

  localparam int NUM_CH = 3;
  localparam int TMR_W  = 16;
  localparam int PDIV   = 4;
`ifdef VALVE_CTRL_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [2:0]        address = '0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [NUM_CH-1:0] out_port;
  logic              irq;

  always #5 clk = ~clk;

  soc_system_valve_ctrl_timed #(.NUM_CH(NUM_CH), .TMR_W(TMR_W), .PRESC_DIV(PDIV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: valves, ticks remaining per channel, flags, cycles since reset.
  bit [NUM_CH-1:0] m_out, m_exp, m_mask;
  int              m_to [NUM_CH];
  int              m_rem[NUM_CH];
  int              m_sel, m_cyc;
  bit              m_irq;

  function automatic void m_reset();
    m_out = '0; m_exp = '0; m_mask = '0; m_sel = 0; m_cyc = 0; m_irq = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin m_to[i] = 0; m_rem[i] = 0; end
  endfunction

  function automatic logic [31:0] m_read(int addr);
    case (addr)
      0: return 32'(m_out);
      3: return 32'(m_sel);
      4: return 32'(m_to[m_sel]);
      5: return 32'(m_exp);
      6: return IRQ_EN ? 32'(m_mask) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_step(bit wr, int addr, logic [31:0] wd);
    bit tick;
    bit [NUM_CH-1:0] nxt, setb, offb, fire, w1c, wl;
    tick = (m_cyc % PDIV) == (PDIV - 1);
    m_cyc++;
    nxt = m_out; setb = '0; offb = '0; fire = '0; w1c = '0;
    wl = wd[NUM_CH-1:0];
    if (IRQ_EN) m_irq = |(m_exp & m_mask);
    if (wr) begin
      case (addr)
        0: begin nxt = wl; setb = wl; offb = ~wl; end
        1: begin nxt = m_out | wl; setb = wl; end
        2: begin nxt = m_out & ~wl; offb = wl; end
        3: if (wd < NUM_CH) m_sel = int'(wd);
        4: m_to[m_sel] = int'(wd[TMR_W-1:0]);
        5: w1c = wl;
        6: if (IRQ_EN) m_mask = wl;
        default: ;
      endcase
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (setb[i] && m_to[i] != 0) begin
        m_rem[i] = m_to[i];
      end else begin
        if (tick && m_out[i] && m_rem[i] == 1) fire[i] = 1'b1;
        if (offb[i]) m_rem[i] = 0;
        else if (tick && m_out[i] && m_rem[i] > 0) m_rem[i]--;
      end
    end
    m_out = nxt & ~fire;
    m_exp = (m_exp & ~w1c) | fire;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(bit cs, bit wrn, int addr, logic [31:0] wd);
    chipselect = cs; write_n = wrn; address = 3'(addr); writedata = wd;
    m_step(cs && !wrn, addr, wd);
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
    chk("out_port", 32'(out_port), 32'(m_out));
    chk("irq", 32'(irq), 32'(m_irq));
  endtask

  task automatic wr(int addr, logic [31:0] wd);
    cyc(1'b1, 1'b0, addr, wd);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b1, 0, 32'd0);
  endtask

  task automatic rd(int addr, string tag);
    chipselect = 1'b1; write_n = 1'b1; address = 3'(addr);
    #1;
    chk(tag, readdata, m_read(addr));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(out_port), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) rd(a, "rst_reg");

    // DATA write and write-only registers reading zero
    wr(0, 32'hFFFF_FFF5);
    chk("data_out", 32'(out_port), 32'h5);
    rd(0, "data_rd"); chk("data_rd_c", readdata, 32'd5);
    rd(1, "set_rd"); rd(2, "clr_rd");
    wr(1, 32'h2); chk("set_out", 32'(out_port), 32'h7);
    wr(2, 32'h1); chk("clr_out", 32'(out_port), 32'h6);

    // Single expiry on channel 1
    wr(0, 32'h0);
    wr(3, 32'd1); rd(3, "chsel");
    wr(3, 32'd7); rd(3, "chsel_ign"); chk("chsel_c", readdata, 32'd1);
    wr(4, 32'hABCD_0003); rd(4, "timeout"); chk("timeout_c", readdata, 32'd3);
    wr(1, 32'h2);
    n = 0;
    while (out_port[1] && n < 30) begin idle(); n++; end
    chk("expire_lat_ok", 32'((n >= 8) && (n <= 16)), 32'd1);
    rd(5, "expired"); chk("expired_c", readdata, 32'h2);
    wr(5, 32'h2); rd(5, "w1c"); chk("w1c_c", readdata, 32'h0);

    // Retrigger every two ticks keeps the valve open
    wr(1, 32'h2);
    for (int k = 0; k < 5; k++) begin
      repeat (7) idle();
      wr(1, 32'h2);
      chk("retrig_on", 32'(out_port[1]), 32'd1);
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (m_rem[1] == 1 && (m_cyc % PDIV) == PDIV - 1) found = 1'b1;
      else idle();
    end
    chk("coinc_found", 32'(found), 32'd1);
    wr(1, 32'h2);
    chk("coinc_on", 32'(out_port[1]), 32'd1);
    rd(5, "coinc_exp"); chk("coinc_exp_c", readdata, 32'd0);

    // Interrupt on expiry of a masked channel
    wr(6, 32'h2); rd(6, "mask");
    n = 0;
    while (out_port[1] && n < 30) begin idle(); n++; end
    idle();
    chk("irq_set", 32'(irq), 32'(IRQ_EN));
    wr(5, 32'h2); idle();
    chk("irq_clr", 32'(irq), 32'd0);

    // Asynchronous reset in the middle of a countdown
    wr(1, 32'h2);
    repeat (5) idle();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out", 32'(out_port), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    rd(5, "arst_exp"); rd(3, "arst_sel"); rd(4, "arst_to");
    wr(3, 32'd1); rd(4, "arst_to1"); chk("arst_to1_c", readdata, 32'd0);
    wr(1, 32'h2);
    repeat (30) idle();
    chk("no_autooff", 32'(out_port[1]), 32'd1);

    // Random traffic against the model
    for (int c = 0; c < NUM_CH; c++) begin
      wr(3, 32'(c));
      wr(4, 32'($urandom_range(1, 6)));
    end
    for (int k = 0; k < 500; k++) begin
      logic [31:0] hi;
      hi = $urandom & 32'hFFFF_0000;
      case ($urandom_range(0, 9))
        0, 1: idle();
        2: wr(0, $urandom);
        3: wr(1, $urandom);
        4: wr(2, $urandom);
        5: wr(3, 32'($urandom_range(0, 4)));
        6: wr(4, hi | 32'($urandom_range(0, 6)));
        7: wr(5, $urandom);
        8: wr(6, $urandom);
        default: cyc(1'($urandom), 1'b1, int'($urandom_range(0, 7)), $urandom);
      endcase
      if ((k % 8) == 7) rd(int'($urandom_range(0, 7)), "rand_rd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
